// File: rtl/malu_seq_if.sv
// Host-side bundle for the sequential matrix ALU: command, load stream,
// result stream and status pulses.
interface malu_seq_if #(
    parameter int BITNESS = 8
);
    logic               i_start;
    logic [7:0]         op_code;
    logic [BITNESS-1:0] size_1;
    logic [BITNESS-1:0] size_2;
    logic               i_valid;
    logic [BITNESS-1:0] i_mat_1;
    logic [BITNESS-1:0] i_mat_2;
    logic               i_stall;
    logic               o_busy;
    logic               o_valid;
    logic [BITNESS-1:0] result_Hi;
    logic [BITNESS-1:0] result_Lo;
    logic               o_ready;
    logic               o_err;

    modport master (
        output i_start, op_code, size_1, size_2,
        output i_valid, i_mat_1, i_mat_2, i_stall,
        input  o_busy, o_valid, result_Hi, result_Lo,
        input  o_ready, o_err
    );

    modport slave (
        input  i_start, op_code, size_1, size_2,
        input  i_valid, i_mat_1, i_mat_2, i_stall,
        output o_busy, o_valid, result_Hi, result_Lo,
        output o_ready, o_err
    );
endinterface

// File: rtl/malu_seq.sv
// Sequential matrix ALU: load two matrices, compute, stream results out.
// Define MALU_SAT_EN to saturate ADD/SUB/MULI and the MAC accumulator.
module malu_seq #(
    parameter int         BITNESS  = 8,
    parameter int         MAX_DIM  = 4,
    parameter logic [7:0] OP_ADD   = 8'h00,
    parameter logic [7:0] OP_SUB   = 8'h01,
    parameter logic [7:0] OP_DOT   = 8'h02,
    parameter logic [7:0] OP_MULI  = 8'h04,
    parameter logic [7:0] OP_TRANS = 8'h06,
    parameter logic [7:0] OP_MMUL  = 8'h07
) (
    input logic      i_clk,
    input logic      reset,
    malu_seq_if.slave bus
);
    localparam int W2 = 2 * BITNESS;
    localparam int N  = MAX_DIM * MAX_DIM;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(MAX_DIM + 1);
    localparam logic [CW-1:0]      ONE  = CW'(1);
    localparam logic [BITNESS-1:0] DLIM = BITNESS'(MAX_DIM);
`ifdef MALU_SAT_EN
    localparam int EW = W2 + 1;
    localparam logic signed [W2-1:0] SMAX = {1'b0, {(W2-1){1'b1}}};
    localparam logic signed [W2-1:0] SMIN = {1'b1, {(W2-1){1'b0}}};
`else
    localparam int EW = W2;
`endif

    typedef logic signed [BITNESS-1:0] elem_t;
    typedef logic signed [W2-1:0]      wide_t;
    typedef logic signed [EW-1:0]      ext_t;

    typedef enum logic [2:0] {
        IDLE, LOAD, COMPUTE, OUTPUT, DONE
    } state_t;

    function automatic wide_t fit(input ext_t x);
`ifdef MALU_SAT_EN
        if (x > ext_t'(SMAX)) return SMAX;
        if (x < ext_t'(SMIN)) return SMIN;
        return wide_t'(x);
`else
        return x;
`endif
    endfunction

    function automatic logic [IW-1:0] addr(
        input logic [CW-1:0] r,
        input logic [CW-1:0] c
    );
        return IW'(int'(r) * MAX_DIM + int'(c));
    endfunction

    state_t        state;
    logic [7:0]    op_q;
    logic [CW-1:0] r_q, c_q;
    logic [CW-1:0] row, col, k;
    wide_t         acc;
    elem_t         scal;
    logic          err_q;

    elem_t m1 [N];
    elem_t m2 [N];

    logic is_sub, is_dot, is_muli, is_trans, is_mmul;
    assign is_sub   = op_q == OP_SUB;
    assign is_dot   = op_q == OP_DOT;
    assign is_muli  = op_q == OP_MULI;
    assign is_trans = op_q == OP_TRANS;
    assign is_mmul  = op_q == OP_MMUL;

    logic known, bad;
    always_comb begin
        known = bus.op_code inside
            {OP_ADD, OP_SUB, OP_DOT, OP_MULI, OP_TRANS, OP_MMUL};
        bad = (bus.size_1 == '0) || (bus.size_2 == '0)
           || (bus.size_1 > DLIM) || (bus.size_2 > DLIM)
           || !known
           || (bus.op_code == OP_MMUL && bus.size_1 != bus.size_2);
    end

    logic          load_en, load_last;
    logic [IW-1:0] la;
    assign load_en   = (state == LOAD) && bus.i_valid;
    assign la        = addr(row, col);
    assign load_last = (row == r_q - ONE) && (col == c_q - ONE);

    always_ff @(posedge i_clk) begin
        if (load_en) begin
            m1[la] <= bus.i_mat_1;
            m2[la] <= bus.i_mat_2;
        end
    end

    // One multiplier shared by DOT (fed from the load stream) and MMUL
    elem_t mac_a, mac_b;
    wide_t prod, acc_next;
    always_comb begin
        mac_a = bus.i_mat_1;
        mac_b = bus.i_mat_2;
        if (state == COMPUTE) begin
            mac_a = m1[addr(row, k)];
            mac_b = m2[addr(k, col)];
        end
    end
    assign prod     = wide_t'(mac_a) * wide_t'(mac_b);
    assign acc_next = fit(ext_t'(acc) + ext_t'(prod));

    elem_t e1, e2;
    wide_t res;
    assign e1 = m1[la];
    assign e2 = m2[la];

    always_comb begin
        res = '0;
        unique case (1'b1)
            is_sub:   res = fit(ext_t'(e1) - ext_t'(e2));
            is_muli:  res = fit(ext_t'(wide_t'(e1) * wide_t'(scal)));
            is_dot,
            is_mmul:  res = acc;
            is_trans: res = wide_t'(m1[addr(col, row)]);
            default:  res = fit(ext_t'(e1) + ext_t'(e2));
        endcase
    end

    // TRANS walks a C x R output grid
    logic [CW-1:0] rlim, clim;
    logic          out_last;
    assign rlim     = is_trans ? c_q : r_q;
    assign clim     = is_trans ? r_q : c_q;
    assign out_last = is_dot
                   || ((row == rlim - ONE) && (col == clim - ONE));

    always_ff @(posedge i_clk) begin
        if (!reset) begin
            state <= IDLE;
            op_q  <= '0;
            r_q   <= '0;
            c_q   <= '0;
            row   <= '0;
            col   <= '0;
            k     <= '0;
            acc   <= '0;
            scal  <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        if (bad) begin
                            err_q <= 1'b1;
                        end else begin
                            op_q  <= bus.op_code;
                            r_q   <= CW'(bus.size_1);
                            c_q   <= CW'(bus.size_2);
                            row   <= '0;
                            col   <= '0;
                            k     <= '0;
                            acc   <= '0;
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (bus.i_valid) begin
                        if (row == '0 && col == '0) scal <= bus.i_mat_2;
                        if (is_dot) acc <= acc_next;
                        if (col == c_q - ONE) begin
                            col <= '0;
                            row <= row + ONE;
                        end else begin
                            col <= col + ONE;
                        end
                        if (load_last) begin
                            row   <= '0;
                            state <= is_mmul ? COMPUTE : OUTPUT;
                        end
                    end
                end
                COMPUTE: begin
                    acc <= acc_next;
                    if (k == r_q - ONE) begin
                        k     <= '0;
                        state <= OUTPUT;
                    end else begin
                        k <= k + ONE;
                    end
                end
                OUTPUT: begin
                    if (!bus.i_stall) begin
                        if (out_last) begin
                            state <= DONE;
                        end else begin
                            if (col == clim - ONE) begin
                                col <= '0;
                                row <= row + ONE;
                            end else begin
                                col <= col + ONE;
                            end
                            if (is_mmul) begin
                                acc   <= '0;
                                state <= COMPUTE;
                            end
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_busy  = state != IDLE;
    assign bus.o_valid = state == OUTPUT;
    assign bus.o_ready = state == DONE;
    assign bus.o_err   = err_q;
    assign {bus.result_Hi, bus.result_Lo} =
        (state == OUTPUT) ? res : '0;
endmodule

// File: tb/tb_malu_seq.sv
// Randomised self-checking bench for malu_seq against a plain-arithmetic
// matrix model.
module tb_malu_seq;
    localparam int BW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    malu_seq_if #(.BITNESS(BW)) bus();

    malu_seq dut (
        .i_clk (clk),
        .reset (rst),
        .bus   (bus)
    );

    int errs   = 0;
    int checks = 0;

    int a [16];
    int b [16];
    logic [15:0] expq [$];

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int clampw(input int x);
`ifdef MALU_SAT_EN
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
`endif
        return x;
    endfunction

    function automatic int rnd8();
        logic [7:0] v;
        v = 8'($urandom);
        return int'($signed(v));
    endfunction

    task automatic build(input int op, input int r, input int c);
        int acc;
        expq.delete();
        case (op)
            0: for (int i = 0; i < r * c; i++)
                   expq.push_back(16'(clampw(a[i] + b[i])));
            1: for (int i = 0; i < r * c; i++)
                   expq.push_back(16'(clampw(a[i] - b[i])));
            4: for (int i = 0; i < r * c; i++)
                   expq.push_back(16'(clampw(a[i] * b[0])));
            2: begin
                acc = 0;
                for (int i = 0; i < r * c; i++)
                    acc = clampw(acc + a[i] * b[i]);
                expq.push_back(16'(acc));
            end
            6: for (int i = 0; i < c; i++)
                   for (int j = 0; j < r; j++)
                       expq.push_back(16'(a[j * c + i]));
            7: for (int i = 0; i < r; i++)
                   for (int j = 0; j < c; j++) begin
                       acc = 0;
                       for (int m = 0; m < r; m++)
                           acc = clampw(acc + a[i * c + m] * b[m * c + j]);
                       expq.push_back(16'(acc));
                   end
            default: ;
        endcase
    endtask

    // Called at posedge+1; returns at posedge+1
    task automatic run(input int op, input int r, input int c,
                       input int smode, input bit gaps);
        int cyc, first, held, nacc;
        bit stall;
        build(op, r, c);
        bus.i_start = 1'b1;
        bus.op_code = 8'(op);
        bus.size_1  = 8'(r);
        bus.size_2  = 8'(c);
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        for (int i = 0; i < r * c; i++) begin
            if (gaps)
                while ($urandom_range(0, 3) == 0) begin
                    bus.i_valid = 1'b0;
                    @(posedge clk); #1;
                end
            bus.i_valid = 1'b1;
            bus.i_mat_1 = 8'(a[i]);
            bus.i_mat_2 = 8'(b[i]);
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
        bus.i_mat_1 = 8'($urandom);
        bus.i_mat_2 = 8'($urandom);
        cyc = 0; first = -1; held = 0; nacc = 0;
        while (expq.size() > 0 && cyc < 400) begin
            stall = 1'b0;
            if (smode == 1) stall = ($urandom_range(0, 2) == 0);
            if (smode == 2) stall = (nacc == 1 && held < 3);
            bus.i_stall = stall;
            @(negedge clk);
            if (bus.o_valid) begin
                if (first < 0) begin
                    first = cyc + 1;
                    check("busy", 32'(bus.o_busy), 1);
                end
                check("data", {bus.result_Hi, bus.result_Lo}, expq[0]);
                if (stall) held++;
                else begin
                    void'(expq.pop_front());
                    nacc++;
                end
            end else begin
                check("idle_zero", {bus.result_Hi, bus.result_Lo}, 0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.i_stall = 1'b0;
        check("timeout", expq.size(), 0);
        check("latency", first, (op == 7) ? r + 1 : 1);
        if (smode == 2) check("stall_held", held, 3);
        @(negedge clk);
        check("done", {bus.o_ready, bus.o_valid}, 2'b10);
        @(posedge clk); #1;
        @(negedge clk);
        check("idle", {bus.o_busy, bus.o_ready}, 2'b00);
        @(posedge clk); #1;
    endtask

    task automatic err_case(input string tag, input int op,
                            input int r, input int c);
        bus.i_start = 1'b1;
        bus.op_code = 8'(op);
        bus.size_1  = 8'(r);
        bus.size_2  = 8'(c);
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        @(negedge clk);
        check({tag, "_pulse"}, {bus.o_err, bus.o_busy}, 2'b10);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_clear"}, {bus.o_err, bus.o_busy}, 2'b00);
        @(posedge clk); #1;
    endtask

    int ops [6] = '{0, 1, 2, 4, 6, 7};

    initial begin
        int op, r, c;
        bus.i_start = 1'b0;
        bus.op_code = '0;
        bus.size_1  = '0;
        bus.size_2  = '0;
        bus.i_valid = 1'b0;
        bus.i_mat_1 = '0;
        bus.i_mat_2 = '0;
        bus.i_stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out",
              {bus.o_busy, bus.o_valid, bus.o_ready, bus.o_err,
               bus.result_Hi, bus.result_Lo}, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        a = '{0:1, 1:2, 2:3, 3:4, default:0};
        b = '{0:5, 1:6, 2:7, 3:8, default:0};
        run(0, 2, 2, 0, 1'b0);
        run(7, 2, 2, 0, 1'b0);
        run(7, 2, 2, 2, 1'b0);

        a = '{0:1, default:0};
        b = '{0:5, default:0};
        run(1, 1, 1, 0, 1'b0);

        a = '{0:1, 1:2, 2:3, 3:4, 4:5, 5:6, default:0};
        run(6, 2, 3, 0, 1'b0);

        a = '{0:127, 1:127, default:0};
        b = '{0:127, 1:127, default:0};
        run(2, 1, 2, 0, 1'b0);
        a = '{0:-128, 1:-128, default:0};
        b = '{0:-128, 1:-128, default:0};
        run(2, 1, 2, 0, 1'b0);

        a = '{0:-7, 1:100, 2:-128, default:0};
        b = '{0:-128, 1:3, 2:9, default:0};
        run(4, 3, 1, 0, 1'b0);

        err_case("r_zero", 0, 0, 2);
        err_case("c_zero", 1, 2, 0);
        err_case("bad_op", 5, 2, 2);
        err_case("too_big", 0, 5, 1);
        err_case("mmul_rect", 7, 2, 3);

        // Reset in the middle of a load
        bus.i_start = 1'b1;
        bus.op_code = 8'h00;
        bus.size_1  = 8'd2;
        bus.size_2  = 8'd2;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.i_valid = 1'b1;
            bus.i_mat_1 = 8'(i + 9);
            bus.i_mat_2 = 8'(i + 3);
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("midreset_out",
              {bus.o_busy, bus.o_valid, bus.o_ready, bus.o_err,
               bus.result_Hi, bus.result_Lo}, 0);
        @(posedge clk); #1;
        a = '{0:1, 1:2, 2:3, 3:4, default:0};
        b = '{0:5, 1:6, 2:7, 3:8, default:0};
        run(0, 2, 2, 0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            op = ops[$urandom_range(0, 5)];
            r  = $urandom_range(1, 4);
            c  = (op == 7) ? r : $urandom_range(1, 4);
            for (int i = 0; i < 16; i++) begin
                a[i] = rnd8();
                b[i] = rnd8();
            end
            run(op, r, c, 1, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/malu_seq.md
Name: malu_seq

Overview:
- Sequential, parametrised matrix ALU; successor to the single-cycle matrix ALU stub in the co-processor datapath.
- Streams two operand matrices in row-major order, stores them in internal register arrays, computes the selected operation, then streams the result out element by element.
- Results are 2*BITNESS wide, split into Hi/Lo halves, with start/valid/stall handshakes toward the host interface.

Parameters:
- BITNESS, 8, element width in bits; signed two's complement.
- MAX_DIM, 4, maximum rows/columns per matrix; storage is MAX_DIM*MAX_DIM per operand.
- OP_ADD, 8'h00, element-wise add.
- OP_SUB, 8'h01, element-wise subtract (mat_1 - mat_2).
- OP_DOT, 8'h02, sum of element-wise products of the flattened matrices.
- OP_MULI, 8'h04, mat_1 times scalar.
- OP_TRANS, 8'h06, transpose of mat_1.
- OP_MMUL, 8'h07, matrix product mat_1 x mat_2; square only.

Ports:
- i_clk  in  1  clock; rising-edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- i_start  in  1  command strobe; sampled in IDLE only.
- op_code  in  8  operation; sampled with i_start.
- size_1  in  BITNESS  row count R; sampled with i_start.
- size_2  in  BITNESS  column count C; sampled with i_start.
- i_valid  in  1  load-element strobe.
- i_mat_1  in  BITNESS  mat_1 element (LOAD).
- i_mat_2  in  BITNESS  mat_2 element (LOAD); scalar for MULI.
- i_stall  in  1  output backpressure.
- o_busy  out  1  high in every state except IDLE.
- o_valid  out  1  result element valid.
- result_Hi  out  BITNESS  upper half of 2*BITNESS result.
- result_Lo  out  BITNESS  lower half of result.
- o_ready  out  1  one-cycle done pulse.
- o_err  out  1  one-cycle error pulse.

Behaviour:
- Reset (reset==0 at a clock edge): enter IDLE; all outputs 0; counters and accumulator cleared. Applies in any state, including mid-operation; storage contents are don't-care after reset.
- States: IDLE, LOAD, COMPUTE, OUTPUT, DONE.
- IDLE:
  - On i_start, latch op_code, R, C.
  - Error if R==0, C==0, R>MAX_DIM, C>MAX_DIM, op_code is unknown, or op is MMUL with R!=C.
  - On error: pulse o_err for 1 cycle and stay in IDLE.
  - Otherwise go to LOAD.
- LOAD:
  - Each i_valid cycle stores one element pair at index (row, col), row-major. The column counter wraps at C-1 into the row counter.
  - Cycles with i_valid=0 are ignored.
  - MULI: only the first i_mat_2 value is kept, as the scalar.
  - DOT: the accumulator adds sext(i_mat_1)*sext(i_mat_2) on each valid element.
  - After the R*C-th element: MMUL goes to COMPUTE, all other ops go to OUTPUT.
- COMPUTE (MMUL only): R cycles of MAC for the current output element (i,j), then go to OUTPUT.
- OUTPUT:
  - o_valid=1 while the current result is presented. If i_stall=1, the data holds and the index does not advance.
  - On a non-stalled cycle the index advances: MMUL returns to COMPUTE for the next element; other ops present the next element on the next cycle.
  - Element counts: R*C elements for ADD/SUB/MULI/MMUL; DOT emits one element; TRANS emits C*R elements in order out(r,c)=mat_1(c,r).
  - After the last accepted element, go to DONE.
- DONE: pulse o_ready for 1 cycle, drive o_valid=0, return to IDLE.
- Arithmetic:
  - Operands are sign-extended to 2*BITNESS; the result is {result_Hi, result_Lo}, wrapping modulo 2^(2*BITNESS).
  - ADD/SUB/TRANS results are sign-extended.
  - MULI/MMUL/DOT products are full 2*BITNESS.
- Latency: first o_valid is 1 cycle after the last LOAD element for ADD/SUB/MULI/TRANS/DOT, and R+1 cycles after it for MMUL.
- i_start outside IDLE is ignored. i_valid outside LOAD is ignored.
- o_valid is 0 in every state except OUTPUT. result_Hi/Lo are 0 when o_valid=0.

Optional Feature:
- Macro: MALU_SAT_EN.
- Defined: DOT/MMUL accumulators and ADD/SUB/MULI results saturate to the signed 2*BITNESS limits (0x7FFF / 0x8000 for BITNESS=8) instead of wrapping.
- Undefined: modulo wrap as specified above; no saturation logic is synthesised.

Test Plan:
- ADD 2x2, BITNESS=8, mat_1 [1 2;3 4], mat_2 [5 6;7 8] -> o_valid for 4 consecutive cycles with Lo=6,8,10,12 and Hi=0; then o_ready pulse.
- SUB 1x1, mat_1=1, mat_2=5 -> Hi=FF, Lo=FC (-4).
- MMUL 2x2 with the same operands as the ADD case -> outputs 19,22,43,50, each preceded by 2 COMPUTE cycles. Repeat with i_stall held 3 cycles on the 2nd element -> data for that element held unchanged, no element lost.
- TRANS R=2, C=3, mat_1 [1 2 3;4 5 6] -> 6 outputs 1,4,2,5,3,6.
- DOT R=1, C=2, mat_1 [127 127], mat_2 [127 127] -> 16'h7E02. Then DOT with mat_1 [-128 -128], mat_2 [-128 -128] -> 16'h8000 wrapped without MALU_SAT_EN; 16'h7FFF with it.
- Error and reset: i_start with R=0 -> o_err pulse, state stays IDLE. i_start with op 8'h05 -> o_err pulse. Drive reset=0 after 2 LOAD elements -> next cycle o_busy=0 and all outputs 0; a following valid ADD command completes correctly.
